// File: rtl/reg_file_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Brief    : Architectural register file x0..x31 with WB->read bypass and a
//             per-register in-flight write scoreboard (busy/stall to decode).
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int MAX_INFL = 3,
    localparam int AW       = $clog2(NREGS),
    localparam int CW       = $clog2(MAX_INFL + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_we,
    input  logic [AW-1:0]   write_addr_WB,
    input  logic [XLEN-1:0] write_data_WB,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_wr,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic            stall
);

    localparam logic [CW-1:0] c_cnt_max = CW'(MAX_INFL);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [CW-1:0]    r_cnt  [NREGS];
    logic [NREGS-1:0] w_inc;
    logic [NREGS-1:0] w_dec;
    logic             w_issue_ok;
    logic             w_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (write_addr_WB != '0)) begin
            r_regs[write_addr_WB] <= write_data_WB;
        end
    end

    // A retiring write to the register being read is forwarded straight from WB.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            if (wb_we && (write_addr_WB == rs1_addr)) rs1_data = write_data_WB;
            else                                      rs1_data = r_regs[rs1_addr];
        end
        if (rs2_addr != '0) begin
            if (wb_we && (write_addr_WB == rs2_addr)) rs2_data = write_data_WB;
            else                                      rs2_data = r_regs[rs2_addr];
        end
    end

    assign w_issue_ok = issue_valid & issue_wr & ~stall;

    for (genvar g = 0; g < NREGS; g++) begin : g_sb
        if (g == 0) begin : g_zero
            assign w_inc[g] = 1'b0;
            assign w_dec[g] = 1'b0;
        end else begin : g_trk
            assign w_inc[g] = w_issue_ok && (issue_rd == AW'(g));
            assign w_dec[g] = wb_we && (write_addr_WB == AW'(g)) && (r_cnt[g] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_one;
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - c_cnt_one;
                end
            end
        end
    end

    // The last outstanding write retiring now is covered by the bypass path.
    always_comb begin
        busy_rs1 = (r_cnt[rs1_addr] != '0) &&
                   !(w_dec[rs1_addr] && (r_cnt[rs1_addr] == c_cnt_one));
        busy_rs2 = (r_cnt[rs2_addr] != '0) &&
                   !(w_dec[rs2_addr] && (r_cnt[rs2_addr] == c_cnt_one));
        w_sat    = issue_valid && issue_wr && (r_cnt[issue_rd] == c_cnt_max);
        stall    = (rs1_used && busy_rs1) || (rs2_used && busy_rs2) || w_sat;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_sb
//  Brief    : Directed + short random bench for reg_file_sb with a reference
//             model feeding an expected-value queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  write_addr_WB;
    logic [31:0] write_data_WB;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_used, rs2_used;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_valid, issue_wr;
    logic [4:0]  issue_rd;
    logic        busy_rs1, busy_rs2, stall;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] m_regs [32];
    int          m_cnt  [32];

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .write_addr_WB(write_addr_WB), .write_data_WB(write_data_WB),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .stall(stall)
    );

    function automatic logic [31:0] m_read(logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && write_addr_WB == a) return write_data_WB;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(logic [4:0] a);
        return (m_cnt[a] != 0) && !(wb_we && write_addr_WB == a && m_cnt[a] == 1);
    endfunction

    function automatic logic m_stall();
        return (rs1_used && m_busy(rs1_addr)) || (rs2_used && m_busy(rs2_addr)) ||
               (issue_valid && issue_wr && m_cnt[issue_rd] == 3);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic push(logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic cmp(string tag, logic [31:0] obs);
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed=%h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic check_all(string tag);
        push(m_read(rs1_addr));
        push(m_read(rs2_addr));
        push({31'd0, m_busy(rs1_addr)});
        push({31'd0, m_busy(rs2_addr)});
        push({31'd0, m_stall()});
        cmp({tag, "/rs1_data"}, rs1_data);
        cmp({tag, "/rs2_data"}, rs2_data);
        cmp({tag, "/busy_rs1"}, {31'd0, busy_rs1});
        cmp({tag, "/busy_rs2"}, {31'd0, busy_rs2});
        cmp({tag, "/stall"},    {31'd0, stall});
    endtask

    // Advance the model with the inputs as they stand, then take one clock edge.
    task automatic step();
        bit st, inc, dec;
        if (!rst_n) begin
            m_reset();
        end else begin
            st  = m_stall();
            inc = issue_valid && !st && issue_wr && issue_rd != 5'd0;
            dec = wb_we && write_addr_WB != 5'd0 && m_cnt[write_addr_WB] != 0;
            if (wb_we && write_addr_WB != 5'd0) m_regs[write_addr_WB] = write_data_WB;
            if (inc) m_cnt[issue_rd]++;
            if (dec) m_cnt[write_addr_WB]--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we = 0; write_addr_WB = '0; write_data_WB = '0;
        rs1_addr = '0; rs2_addr = '0; rs1_used = 0; rs2_used = 0;
        issue_valid = 0; issue_rd = '0; issue_wr = 0;
    endtask

    task automatic issue(logic [4:0] rd);
        issue_valid = 1; issue_wr = 1; issue_rd = rd;
    endtask

    task automatic wb(logic [4:0] a, logic [31:0] d);
        wb_we = 1; write_addr_WB = a; write_data_WB = d;
    endtask

    initial begin
        idle();
        m_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        #1 check_all("reset_init");

        // x0 is hardwired: writes dropped, issues untracked
        step(); idle();
        wb(5'd0, 32'hDEAD_BEEF); rs1_addr = 5'd0;
        #1 push(32'd0); cmp("x0_wb_read", rs1_data);
        step(); idle();
        rs1_addr = 5'd0;
        #1 push(32'd0); cmp("x0_after_wb", rs1_data);
        issue(5'd0); rs1_used = 1;
        #1 check_all("x0_issue");
        step(); idle();
        rs1_addr = 5'd0; rs1_used = 1;
        #1 push(32'd0); cmp("x0_busy", {31'd0, busy_rs1});

        // Same-cycle bypass, then registered value
        step(); idle();
        wb(5'd5, 32'h1234_5678); rs2_addr = 5'd5;
        #1 push(32'h1234_5678); cmp("bypass_rs2", rs2_data);
        step(); idle();
        rs2_addr = 5'd5;
        #1 push(32'h1234_5678); cmp("stored_rs2", rs2_data);

        // RAW hazard on x7; an issue attempted while stalled must be ignored
        step(); idle();
        issue(5'd7);
        step(); idle();
        rs1_addr = 5'd7; rs1_used = 1;
        #1 push(32'd1); cmp("raw_busy", {31'd0, busy_rs1});
        push(32'd1); cmp("raw_stall", {31'd0, stall});
        issue(5'd7);
        #1 check_all("raw_stalled_issue");
        step(); idle();
        rs1_addr = 5'd7; rs1_used = 1; wb(5'd7, 32'hA5A5_0707);
        #1 push(32'd0); cmp("raw_retire_busy", {31'd0, busy_rs1});
        push(32'd0); cmp("raw_retire_stall", {31'd0, stall});
        push(32'hA5A5_0707); cmp("raw_retire_data", rs1_data);
        step(); idle();
        rs1_addr = 5'd7; rs1_used = 1;
        #1 check_all("raw_cleared");

        // Simultaneous issue + retire on x9 with one outstanding write
        step(); idle();
        issue(5'd9);
        step(); idle();
        issue(5'd9); wb(5'd9, 32'h0909_0909); rs1_addr = 5'd9;
        #1 check_all("simul_cycle");
        step(); idle();
        rs1_addr = 5'd9;
        #1 push(32'd1); cmp("simul_busy_after", {31'd0, busy_rs1});
        wb(5'd9, 32'h9999_0000);
        step(); idle();
        rs1_addr = 5'd9;
        #1 push(32'd0); cmp("simul_retired", {31'd0, busy_rs1});

        // Saturation on x3
        for (int k = 0; k < 3; k++) begin
            idle(); issue(5'd3);
            #1 push(32'd0); cmp($sformatf("sat_issue%0d_stall", k), {31'd0, stall});
            step();
        end
        idle(); issue(5'd3);
        #1 push(32'd1); cmp("sat_4th_stall", {31'd0, stall});
        step(); idle();
        for (int k = 0; k < 3; k++) begin
            idle(); wb(5'd3, 32'h3300_0000 + 32'(k)); rs2_addr = 5'd3;
            #1 push((k == 2) ? 32'd0 : 32'd1);
            cmp($sformatf("sat_retire%0d_busy", k), {31'd0, busy_rs2});
            step();
        end
        idle(); rs2_addr = 5'd3;
        #1 check_all("sat_drained");
        wb(5'd3, 32'h3333_3333);
        step(); idle();
        rs2_addr = 5'd3; issue(5'd3);
        #1 check_all("untracked_wb");
        step(); idle();
        rs2_addr = 5'd3;
        #1 push(32'd1); cmp("no_underflow_busy", {31'd0, busy_rs2});
        wb(5'd3, 32'h3030_3030);
        step();

        // Random traffic against the model
        for (int k = 0; k < 40; k++) begin
            idle();
            if ($urandom_range(0, 1) == 1) wb(5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                issue_valid = 1; issue_wr = 1'($urandom_range(0, 1));
                issue_rd = 5'($urandom_range(0, 7));
            end
            rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 31));
            rs1_used = 1'($urandom_range(0, 1)); rs2_used = 1'($urandom_range(0, 1));
            #1 check_all($sformatf("rand%0d", k));
            step();
        end

        // Async reset mid-run with a pending write on x7
        idle(); wb(5'd5, 32'h5555_AAAA); issue(5'd7);
        step(); idle();
        rs1_addr = 5'd5; rs2_addr = 5'd7; rs2_used = 1;
        rst_n = 0; m_reset();
        #1 push(32'd0); cmp("rst_rs1_data", rs1_data);
        push(32'd0); cmp("rst_rs2_data", rs2_data);
        push(32'd0); cmp("rst_busy_rs2", {31'd0, busy_rs2});
        push(32'd0); cmp("rst_stall", {31'd0, stall});
        for (int a = 0; a < 32; a += 2) begin
            rs1_addr = 5'(a); rs2_addr = 5'(a + 1);
            #1 check_all($sformatf("rst_scan%0d", a));
            step();
        end
        rst_n = 1;
        rs1_addr = 5'd5; rs2_addr = 5'd7; rs2_used = 1;
        #1 check_all("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
